// File: rtl/col_pp_if.sv
// Column post-processing stream interface.
// Carries the input column handshake and the output column bundle.
interface col_pp_if #(
  parameter int DW  = 32,
  parameter int HIT = 56,
  parameter int OW  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DW*HIT-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OW*HIT-1:0] out_data;
  logic [5:0]        out_col;
  logic [5:0]        out_chnl;
  logic              frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_col, out_chnl, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_col, out_chnl, frame_done
  );
endinterface

// File: rtl/col_post_proc.sv
// Per-column bias add, ReLU, rounding shift and saturation.
// Two-stage valid/ready pipeline with column/channel tagging.
module col_post_proc #(
  parameter int DW  = 32,
  parameter int HIT = 56,
  parameter int WID = 56,
  parameter int NCH = 64,
  parameter int OW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bias_we,
  input  logic [5:0]           bias_addr,
  input  logic signed [DW-1:0] bias_wdata,
  input  logic [4:0]           shift_cfg,
  col_pp_if.slave              bus
);
  localparam int SW = DW + 1;
  localparam int RW = DW + 2;

  logic                 s1_valid_q;
  logic                 s2_valid_q;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 accept;
  logic [5:0]           col_cnt_q;
  logic [5:0]           col_cnt_d;
  logic [5:0]           chnl_cnt_q;
  logic [5:0]           chnl_cnt_d;
  logic [5:0]           s1_col_q;
  logic [5:0]           s1_chnl_q;
  logic signed [SW-1:0] s1_sum_q [HIT];
  logic signed [SW-1:0] s1_sum_d [HIT];
  logic signed [DW-1:0] bias_q [NCH];
  logic signed [DW-1:0] bias_sel;
  logic [OW*HIT-1:0]    out_data_q;
  logic [OW*HIT-1:0]    out_data_d;
  logic [5:0]           out_col_q;
  logic [5:0]           out_chnl_q;
  logic                 frame_done_q;
  logic signed [SW-1:0] sum;
  logic [RW-1:0]        pos;
  logic [RW-1:0]        rnd;

  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign accept   = bus.in_valid && s1_adv;
  assign bias_sel = bias_q[chnl_cnt_q];

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_chnl   = out_chnl_q;
  assign bus.frame_done = s2_valid_q && frame_done_q;

  always_comb begin
    col_cnt_d  = col_cnt_q;
    chnl_cnt_d = chnl_cnt_q;
    if (accept) begin
      if (col_cnt_q == 6'(WID - 1)) begin
        col_cnt_d  = '0;
        chnl_cnt_d = (chnl_cnt_q == 6'(NCH - 1)) ?
                     '0 : chnl_cnt_q + 6'd1;
      end else begin
        col_cnt_d = col_cnt_q + 6'd1;
      end
    end
  end

  // DW+1 bits hold any DW-bit sum, so the add cannot wrap
  always_comb begin
    for (int r = 0; r < HIT; r++) begin
      s1_sum_d[r] = SW'($signed(bus.in_data[DW*r +: DW]))
                  + SW'(bias_sel);
    end
  end

  always_comb begin
    out_data_d = '0;
    sum        = '0;
    pos        = '0;
    rnd        = '0;
    for (int r = 0; r < HIT; r++) begin
      sum = s1_sum_q[r];
      pos = sum[SW-1] ? '0 : RW'(sum);
      if (shift_cfg == 5'd0) begin
        rnd = pos;
      end else begin
        rnd = (pos + (RW'(1) << (shift_cfg - 5'd1))) >> shift_cfg;
      end
      out_data_d[OW*r +: OW] = (|rnd[RW-1:OW]) ? '1 : rnd[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q  <= '0;
      chnl_cnt_q <= '0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      chnl_cnt_q <= chnl_cnt_d;
    end
  end

  // a write racing an accept lands after the accept has read the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) bias_q[c] <= '0;
    end else if (bias_we) begin
      bias_q[bias_addr] <= bias_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_col_q   <= '0;
      s1_chnl_q  <= '0;
      for (int r = 0; r < HIT; r++) s1_sum_q[r] <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (accept) begin
        s1_col_q  <= col_cnt_q;
        s1_chnl_q <= chnl_cnt_q;
        for (int r = 0; r < HIT; r++) s1_sum_q[r] <= s1_sum_d[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_col_q    <= '0;
      out_chnl_q   <= '0;
      frame_done_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= out_data_d;
        out_col_q    <= s1_col_q;
        out_chnl_q   <= s1_chnl_q;
        frame_done_q <= (s1_col_q == 6'(WID - 1)) &&
                        (s1_chnl_q == 6'(NCH - 1));
      end
    end
  end
endmodule

// File: tb/tb_col_post_proc.sv
// Directed bench for col_post_proc with a queue-based
// reference model checked on every cycle.
module tb_col_post_proc;
  localparam int DW  = 32;
  localparam int HIT = 56;
  localparam int WID = 56;
  localparam int NCH = 64;
  localparam int OW  = 8;

  typedef logic [DW*HIT-1:0] icol_t;
  typedef logic [OW*HIT-1:0] ocol_t;

  typedef struct {
    ocol_t data;
    int    col;
    int    chnl;
    bit    fd;
    int    stamp;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 bias_we = 1'b0;
  logic [5:0]           bias_addr = '0;
  logic signed [DW-1:0] bias_wdata = '0;
  logic [4:0]           shift_cfg = '0;

  col_pp_if #(.DW(DW), .HIT(HIT), .OW(OW)) bus ();

  col_post_proc #(
    .DW(DW), .HIT(HIT), .WID(WID), .NCH(NCH), .OW(OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bias_we    (bias_we),
    .bias_addr  (bias_addr),
    .bias_wdata (bias_wdata),
    .shift_cfg  (shift_cfg),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   n_acc   = 0;
  int   col_m   = 0;
  int   chnl_m  = 0;
  int   bias_m [NCH];
  exp_t q[$];
  exp_t lg[$];

  task automatic chk(input string nm, input ocol_t act,
                     input ocol_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic ocol_t model(input icol_t d, input int b,
                                  input int s);
    ocol_t  o;
    longint x;
    o = '0;
    for (int r = 0; r < HIT; r++) begin
      x = longint'($signed(d[DW*r +: DW])) + longint'(b);
      if (x < 0) x = 0;
      else if (s > 0) x = (x + (longint'(1) << (s - 1))) >> s;
      if (x > (1 << OW) - 1) x = (1 << OW) - 1;
      o[OW*r +: OW] = OW'(x);
    end
    return o;
  endfunction

  function automatic icol_t col4(input int a, input int b,
                                 input int c, input int d);
    icol_t v;
    v = '0;
    v[DW*0 +: DW] = DW'(a);
    v[DW*1 +: DW] = DW'(b);
    v[DW*2 +: DW] = DW'(c);
    v[DW*3 +: DW] = DW'(d);
    return v;
  endfunction

  function automatic icol_t mkcol(input int k);
    icol_t v;
    for (int r = 0; r < HIT; r++)
      v[DW*r +: DW] = DW'(((k * 131 + r * 977) % 5000) - 1500);
    return v;
  endfunction

  function automatic int el(input ocol_t d, input int r);
    return int'(d[OW*r +: OW]);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      col_m  = 0;
      chnl_m = 0;
      for (int c = 0; c < NCH; c++) bias_m[c] = 0;
      chk("rst_out_valid", ocol_t'(bus.out_valid), 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_col", ocol_t'(bus.out_col), 0);
      chk("rst_out_chnl", ocol_t'(bus.out_chnl), 0);
      chk("rst_frame_done", ocol_t'(bus.frame_done), 0);
    end else begin
      chk("out_valid", ocol_t'(bus.out_valid),
          ocol_t'(q.size() > 0 && cyc - q[0].stamp >= 2));
      chk("in_ready", ocol_t'(bus.in_ready),
          ocol_t'(!(q.size() >= 2 && !bus.out_ready)));
      if (bus.out_valid && q.size() > 0) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_col", ocol_t'(bus.out_col), ocol_t'(q[0].col));
        chk("out_chnl", ocol_t'(bus.out_chnl), ocol_t'(q[0].chnl));
        chk("frame_done", ocol_t'(bus.frame_done),
            ocol_t'(q[0].fd));
        if (bus.out_ready) begin
          lg.push_back(q[0]);
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.data  = model(bus.in_data, bias_m[chnl_m], int'(shift_cfg));
        e.col   = col_m;
        e.chnl  = chnl_m;
        e.fd    = (col_m == WID - 1) && (chnl_m == NCH - 1);
        e.stamp = cyc;
        q.push_back(e);
        n_acc++;
        col_m++;
        if (col_m == WID) begin
          col_m  = 0;
          chnl_m = (chnl_m + 1) % NCH;
        end
      end
      if (bias_we) bias_m[bias_addr] = int'(bias_wdata);
    end
  end

  task automatic push(input icol_t d);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wbias(input int a, input int v);
    bias_we    = 1'b1;
    bias_addr  = 6'(a);
    bias_wdata = DW'(v);
    @(posedge clk);
    #1;
    bias_we = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 200) begin
      t++;
      @(posedge clk);
    end
    if (t >= 200) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("in_ready_after_rst", ocol_t'(bus.in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int b;
    int nfd;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // basic: bias 10, shift 2
    wbias(0, 10);
    shift_cfg = 5'd2;
    b = lg.size();
    push(col4(5, -20, 1000, 0));
    drain();
    chk("basic_e0", ocol_t'(el(lg[b].data, 0)), 4);
    chk("basic_e1", ocol_t'(el(lg[b].data, 1)), 0);
    chk("basic_e2", ocol_t'(el(lg[b].data, 2)), 253);
    chk("basic_e3", ocol_t'(el(lg[b].data, 3)), 3);

    // saturation and rounding
    wbias(0, 0);
    shift_cfg = 5'd0;
    b = lg.size();
    push(col4(300, 255, -1, 0));
    drain();
    chk("sat_e0", ocol_t'(el(lg[b].data, 0)), 255);
    chk("sat_e1", ocol_t'(el(lg[b].data, 1)), 255);
    chk("sat_e2", ocol_t'(el(lg[b].data, 2)), 0);
    shift_cfg = 5'd1;
    b = lg.size();
    push(col4(300, 255, -1, 3));
    drain();
    chk("rnd_e3", ocol_t'(el(lg[b].data, 3)), 2);
    chk("rnd_e0", ocol_t'(el(lg[b].data, 0)), 150);

    // backpressure
    do_reset();
    shift_cfg = 5'd3;
    b = lg.size();
    fork
      begin
        int a0;
        a0 = n_acc;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        chk("bp_accepts", ocol_t'(n_acc - a0), 2);
        chk("bp_in_ready", ocol_t'(bus.in_ready), 0);
        #1;
        bus.out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 5; k++) push(mkcol(k));
      end
    join
    drain();
    chk("bp_count", ocol_t'(lg.size() - b), 5);
    for (int k = 0; k < 5; k++)
      chk("bp_col_order", ocol_t'(lg[b + k].col), ocol_t'(k));

    // full frame wrap
    do_reset();
    for (int c = 0; c < NCH; c++) wbias(c, c * 3 - 50);
    b = lg.size();
    for (int k = 0; k <= WID * NCH; k++) push(mkcol(k));
    drain();
    nfd = 0;
    for (int k = 0; k <= WID * NCH; k++) nfd += int'(lg[b + k].fd);
    chk("wrap_fd_count", ocol_t'(nfd), 1);
    chk("wrap_fd_last", ocol_t'(lg[b + 3583].fd), 1);
    chk("wrap_last_col", ocol_t'(lg[b + 3583].col), 55);
    chk("wrap_last_chnl", ocol_t'(lg[b + 3583].chnl), 63);
    chk("wrap_chnl_step", ocol_t'(lg[b + 56].chnl), 1);
    chk("wrap_next_col", ocol_t'(lg[b + 3584].col), 0);
    chk("wrap_next_chnl", ocol_t'(lg[b + 3584].chnl), 0);

    // bias write racing an accept on channel 0
    do_reset();
    shift_cfg = 5'd0;
    b = lg.size();
    bias_we    = 1'b1;
    bias_addr  = 6'd0;
    bias_wdata = DW'(7);
    push(col4(100, 0, 0, 0));
    bias_we = 1'b0;
    push(col4(100, 0, 0, 0));
    drain();
    chk("coll_old", ocol_t'(el(lg[b].data, 0)), 100);
    chk("coll_new", ocol_t'(el(lg[b + 1].data, 0)), 107);

    // reset with both stages full
    for (int k = 0; k < 3; k++) push(mkcol(k + 7));
    chk("pre_rst_valid", ocol_t'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", ocol_t'(bus.out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b = lg.size();
    push(col4(50, 0, 0, 0));
    drain();
    chk("post_rst_col", ocol_t'(lg[b].col), 0);
    chk("post_rst_chnl", ocol_t'(lg[b].chnl), 0);
    chk("post_rst_bias", ocol_t'(el(lg[b].data, 0)), 50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
